// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus between the decode pipeline (master) and the hazard scoreboard (slave).
// The ID instruction is offered with id_valid. It enters EX on a rising edge where stall=0 and flush=0;
// while stall=1 the master holds the same ID fields, and flush=1 discards the offer for that edge.
interface hazard_scoreboard_if #(
  parameter int RA_W   = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = $clog2(STAGES)
);
  logic              id_valid;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RA_W-1:0]   id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_is_ecall;
  logic              flush;

  logic              stall;
  logic [SEL_W-1:0]  ex_fwd_rs1;
  logic [SEL_W-1:0]  ex_fwd_rs2;
  logic              id_bypass_rs1;
  logic              id_bypass_rs2;
  logic              is_halted;
  logic [CNT_W-1:0]  retire_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_is_ecall, flush,
    input  stall, ex_fwd_rs1, ex_fwd_rs2, id_bypass_rs1, id_bypass_rs2,
           is_halted, retire_count, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_is_ecall, flush,
    output stall, ex_fwd_rs1, ex_fwd_rs2, id_bypass_rs1, id_bypass_rs2,
           is_halted, retire_count, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight instructions after ID and derives load-use stalls, EX forward selects,
// ID write-back bypass, sticky ecall halt and saturating retire/stall counters.
module hazard_scoreboard #(
  parameter int  RA_W       = 5,
  parameter int  STAGES     = 3,
  parameter int  LOAD_READY = 2,
  parameter int  CNT_W      = 32,
  localparam int SEL_W      = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            ecall;
  } slot_t;

  slot_t             slots [STAGES];
  slot_t             id_slot;
  logic [STAGES-1:0] match_rs1;
  logic [STAGES-1:0] match_rs2;
  logic [STAGES-1:0] load_hit;
  logic              stall_int;
  logic              load_id;
  logic              halted_q;
  logic [SEL_W-1:0]  fwd_rs1_q, fwd_rs2_q;
  logic [SEL_W-1:0]  fwd_rs1_nxt, fwd_rs2_nxt;
  logic [CNT_W-1:0]  retire_q, stall_q;
  logic              retire_evt;

  // Nearest producer wins: the youngest slot (lowest index) below WB that matches.
  function automatic logic [SEL_W-1:0] nearest(input logic [STAGES-1:0] m);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = STAGES - 2; k >= 0; k--) begin
      if (m[k]) sel = SEL_W'(k + 1);
    end
    return sel;
  endfunction

  always_comb begin
    match_rs1 = '0;
    match_rs2 = '0;
    load_hit  = '0;
    for (int k = 0; k < STAGES; k++) begin
      match_rs1[k] = slots[k].valid && slots[k].reg_write && (slots[k].rd == sb.id_rs1)
                     && (sb.id_rs1 != '0) && sb.id_use_rs1;
      match_rs2[k] = slots[k].valid && slots[k].reg_write && (slots[k].rd == sb.id_rs2)
                     && (sb.id_rs2 != '0) && sb.id_use_rs2;
      load_hit[k]  = (match_rs1[k] || match_rs2[k]) && slots[k].mem_read
                     && ((k + 1) < LOAD_READY);
    end
  end

  // Reset forces the combinational outputs low so an in-progress stall drops immediately.
  always_comb begin
    stall_int   = !reset && sb.id_valid && !sb.flush && !halted_q && (|load_hit);
    load_id     = sb.id_valid && !sb.flush && !stall_int && !halted_q;
    fwd_rs1_nxt = load_id ? nearest(match_rs1) : '0;
    fwd_rs2_nxt = load_id ? nearest(match_rs2) : '0;
    retire_evt  = slots[STAGES-1].valid && !halted_q;
  end

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = 1'b1;
    id_slot.rd        = sb.id_rd;
    id_slot.reg_write = sb.id_reg_write;
    id_slot.mem_read  = sb.id_mem_read;
    id_slot.ecall     = sb.id_is_ecall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) slots[k] <= '0;
    end else begin
      slots[0] <= load_id ? id_slot : '0;
      for (int k = 1; k < STAGES; k++) slots[k] <= slots[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_rs1_q <= '0;
      fwd_rs2_q <= '0;
    end else begin
      fwd_rs1_q <= fwd_rs1_nxt;
      fwd_rs2_q <= fwd_rs2_nxt;
    end
  end

  // The ecall retires on the same edge that sets halt, since halt is still clear there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      if (slots[STAGES-1].valid && slots[STAGES-1].ecall) halted_q <= 1'b1;
      if (retire_evt && (retire_q != '1)) retire_q <= retire_q + CNT_W'(1);
      if (stall_int && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    sb.stall         = stall_int;
    sb.ex_fwd_rs1    = fwd_rs1_q;
    sb.ex_fwd_rs2    = fwd_rs2_q;
    sb.id_bypass_rs1 = !reset && match_rs1[STAGES-1] && !(|match_rs1[STAGES-2:0]);
    sb.id_bypass_rs2 = !reset && match_rs2[STAGES-1] && !(|match_rs2[STAGES-2:0]);
    sb.is_halted     = halted_q;
    sb.retire_count  = retire_q;
    sb.stall_count   = stall_q;
  end

endmodule
